// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin arbiter that lends a shared external ALU to two
//            requesters, one operation in flight, with a buffered response.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter logic [5:0] OPC_MAX = 6'b010000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [5:0]  req0_opcode,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [5:0]  req1_opcode,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_ovf,
    output logic        rsp_err,
    output logic [5:0]  alu_opcode,
    output logic [31:0] alu_opnd1,
    output logic [31:0] alu_opnd2,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_ptr;
    logic [5:0]  r_opc;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_id;
    logic        r_rsp_id;
    logic [31:0] r_rsp_result;
    logic        r_rsp_zero;
    logic        r_rsp_ovf;
    logic        r_rsp_err;

    logic        w_grant_id;
    logic        w_accept;
    logic        w_illegal;
    logic [5:0]  w_sel_opc;
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_b;

    // On a tie the requester that did not win last time gets the grant.
    assign w_grant_id = (req0_valid & req1_valid) ? ~r_ptr : req1_valid;
    assign w_accept   = (r_state == S_IDLE) & (req0_valid | req1_valid) & ~reset;
    assign w_sel_opc  = w_grant_id ? req1_opcode : req0_opcode;
    assign w_sel_a    = w_grant_id ? req1_a      : req0_a;
    assign w_sel_b    = w_grant_id ? req1_b      : req0_b;
    assign w_illegal  = (r_opc > OPC_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req0_ready = req0_valid & ~w_grant_id & ~reset;
                req1_ready = req1_valid &  w_grant_id & ~reset;
            end
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr        <= 1'b1;
            r_opc        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_ovf    <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ptr <= w_grant_id;
                r_id  <= w_grant_id;
                r_opc <= w_sel_opc;
                r_a   <= w_sel_a;
                r_b   <= w_sel_b;
            end
            // Illegal opcodes still take the EXEC slot but report a clean error.
            if (r_state == S_EXEC) begin
                r_rsp_id     <= r_id;
                r_rsp_result <= w_illegal ? 32'd0 : alu_out;
                r_rsp_zero   <= ~w_illegal & alu_zero;
                r_rsp_ovf    <= ~w_illegal & alu_ovf;
                r_rsp_err    <= w_illegal;
            end
        end
    end

    assign alu_opcode = r_opc;
    assign alu_opnd1  = r_a;
    assign alu_opnd2  = r_b;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_ovf    = r_rsp_ovf;
    assign rsp_err    = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam logic [5:0] OPC_MAX = 6'b010000;

    typedef struct packed {logic [31:0] res; logic zero; logic ovf;} alu_t;
    typedef struct packed {logic id; logic [31:0] res; logic zero; logic ovf; logic err;} rsp_t;
    typedef struct packed {logic id; logic [5:0] opc; logic [31:0] a; logic [31:0] b;} op_t;
    typedef struct {logic who; logic [5:0] op; logic [31:0] a; logic [31:0] b; rsp_t exp;} vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [5:0]  req0_opcode, req1_opcode;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_ovf, rsp_err;
    logic [31:0] rsp_result;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_opnd1, alu_opnd2, alu_out;
    logic        alu_zero, alu_ovf;
    alu_t        alu_r;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.OPC_MAX(OPC_MAX)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .alu_opcode(alu_opcode), .alu_opnd1(alu_opnd1), .alu_opnd2(alu_opnd2),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf)
    );

    // Shared ALU: 0 = add (ovf = carry), 1 = subtract (ovf = borrow), else xor.
    function automatic alu_t alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        alu_t        r;
        case (op)
            6'd0:    begin w = {1'b0, a} + {1'b0, b}; r.res = w[31:0]; r.ovf = w[32]; end
            6'd1:    begin w = {1'b0, a} - {1'b0, b}; r.res = w[31:0]; r.ovf = w[32]; end
            default: begin r.res = a ^ b; r.ovf = 1'b0; end
        endcase
        r.zero = (r.res == 32'd0);
        return r;
    endfunction

    always_comb alu_r = alu_fn(alu_opcode, alu_opnd1, alu_opnd2);
    assign alu_out  = alu_r.res;
    assign alu_zero = alu_r.zero;
    assign alu_ovf  = alu_r.ovf;

    function automatic rsp_t exp_rsp(input op_t o);
        rsp_t r;
        alu_t x;
        x = alu_fn(o.opc, o.a, o.b);
        if (o.opc > OPC_MAX) r = '{o.id, 32'd0, 1'b0, 1'b0, 1'b1};
        else                 r = '{o.id, x.res, x.zero, x.ovf, 1'b0};
        return r;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- transaction-level reference model ----------------
    op_t  m_q[$];
    int   m_age  = 0;
    logic m_last = 1'b1;
    op_t  m_lat  = '0;
    rsp_t m_rsp  = '0;

    always begin
        logic e0, e1, g;
        op_t  o;
        @(negedge clk);
        #1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (m_q.size() == 0 && !reset) begin
            g  = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e0 = req0_valid && !g;
            e1 = req1_valid && g;
        end
        check("req0_ready", 72'(req0_ready), 72'(e0));
        check("req1_ready", 72'(req1_ready), 72'(e1));
        check("rsp_valid", 72'(rsp_valid), 72'(m_q.size() != 0 && m_age >= 1));
        check("rsp_fields", 72'({rsp_id, rsp_result, rsp_zero, rsp_ovf, rsp_err}), 72'(m_rsp));
        check("alu_drive", 72'({alu_opcode, alu_opnd1, alu_opnd2}), 72'({m_lat.opc, m_lat.a, m_lat.b}));
        @(posedge clk);
        if (reset) begin
            m_q.delete();
            m_last = 1'b1;
            m_lat  = '0;
            m_rsp  = '0;
        end else if (m_q.size() != 0) begin
            if (m_age == 0) begin
                m_age = 1;
                m_rsp = exp_rsp(m_q[0]);
            end else if (rsp_ready) begin
                m_q.delete();
            end
        end else if (req0_valid || req1_valid) begin
            g = (req0_valid && req1_valid) ? !m_last : req1_valid;
            o = g ? '{1'b1, req1_opcode, req1_a, req1_b} : '{1'b0, req0_opcode, req0_a, req0_b};
            m_q.push_back(o);
            m_age  = 0;
            m_last = g;
            m_lat  = o;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [5:0] rnd_op();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 4)  return 6'd0;
        if (r < 7)  return 6'd1;
        if (r == 7) return 6'($urandom_range(2, 16));
        if (r == 8) return ($urandom_range(0, 1) == 0) ? 6'd16 : 6'd17;
        return 6'($urandom_range(17, 63));
    endfunction

    function automatic vec_t mkv(input logic who, input logic [5:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] res,
                                 input logic z, input logic o, input logic e);
        vec_t v;
        v.who = who; v.op = op; v.a = a; v.b = b;
        v.exp = '{who, res, z, o, e};
        return v;
    endfunction

    vec_t vecs[7];
    rsp_t snap;

    initial begin
        int   t;
        logic acc0, acc1;

        vecs[0] = mkv(1'b0, 6'd0,  32'd5,        32'd7,        32'd12,         1'b0, 1'b0, 1'b0);
        vecs[1] = mkv(1'b1, 6'd0,  32'hFFFFFFFF, 32'd1,        32'd0,          1'b1, 1'b1, 1'b0);
        vecs[2] = mkv(1'b0, 6'h3F, 32'd4,        32'd9,        32'd0,          1'b0, 1'b0, 1'b1);
        vecs[3] = mkv(1'b1, 6'd16, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00,   1'b0, 1'b0, 1'b0);
        vecs[4] = mkv(1'b0, 6'd17, 32'd3,        32'd3,        32'd0,          1'b0, 1'b0, 1'b1);
        vecs[5] = mkv(1'b1, 6'd1,  32'd2,        32'd5,        32'hFFFFFFFD,   1'b0, 1'b1, 1'b0);
        vecs[6] = mkv(1'b0, 6'd1,  32'd9,        32'd9,        32'd0,          1'b1, 1'b0, 1'b0);

        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_opcode = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_opcode = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(negedge clk);
        #2;
        check("reset_rsp_valid", 72'(rsp_valid), 72'd0);
        check("reset_rsp", 72'({rsp_id, rsp_result, rsp_zero, rsp_ovf, rsp_err}), 72'd0);
        check("reset_alu", 72'({alu_opcode, alu_opnd1, alu_opnd2}), 72'd0);

        // Single transactions with fixed two-cycle latency.
        @(negedge clk);
        reset = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i != 0) @(negedge clk);
            req0_valid = !vecs[i].who; req1_valid = vecs[i].who;
            req0_opcode = vecs[i].op; req1_opcode = vecs[i].op;
            req0_a = vecs[i].a; req1_a = vecs[i].a;
            req0_b = vecs[i].b; req1_b = vecs[i].b;
            #2;
            check("vec_ready", 72'({req1_ready, req0_ready}), vecs[i].who ? 72'd2 : 72'd1);
            @(negedge clk);
            req0_valid = 1'b0; req1_valid = 1'b0;
            #2;
            check("vec_exec_no_rsp", 72'(rsp_valid), 72'd0);
            @(negedge clk);
            #2;
            check("vec_rsp_valid", 72'(rsp_valid), 72'd1);
            check("vec_rsp", 72'({rsp_id, rsp_result, rsp_zero, rsp_ovf, rsp_err}), 72'(vecs[i].exp));
        end

        // Both requesters valid continuously after reset: grants alternate 0,1,0,1.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req0_valid = 1'b1; req0_opcode = 6'd1; req0_a = 32'd3; req0_b = 32'd3;
        req1_valid = 1'b1; req1_opcode = 6'd1; req1_a = 32'd3; req1_b = 32'd3;
        #2;
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (!(req0_ready || req1_ready) && t < 8) begin @(negedge clk); #2; t++; end
            check("rr_grant_wait", 72'(t < 8), 72'd1);
            check("rr_grant", 72'({req1_ready, req0_ready}), (k % 2 == 1) ? 72'd2 : 72'd1);
            t = 0;
            do begin @(negedge clk); #2; t++; end while (!rsp_valid && t < 8);
            check("rr_rsp_wait", 72'(t < 8), 72'd1);
            check("rr_rsp", 72'({rsp_id, rsp_result, rsp_zero, rsp_ovf, rsp_err}),
                  72'({(k % 2 == 1), 32'd0, 1'b1, 1'b0, 1'b0}));
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Consumer stalls for 5 cycles while req1 waits.
        req0_valid = 1'b1; req0_opcode = 6'd0; req0_a = 32'd10; req0_b = 32'd20;
        rsp_ready = 1'b0;
        #2;
        check("hold_acc0", 72'(req0_ready), 72'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_opcode = 6'd0; req1_a = 32'd1; req1_b = 32'd2;
        #2;
        check("hold_exec_r1", 72'(req1_ready), 72'd0);
        @(negedge clk);
        #2;
        snap = '{rsp_id, rsp_result, rsp_zero, rsp_ovf, rsp_err};
        check("hold_rsp", 72'(snap), 72'({1'b0, 32'd30, 1'b0, 1'b0, 1'b0}));
        for (int i = 0; i < 5; i++) begin
            check("hold_stable", 72'({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_ovf, rsp_err}),
                  72'({1'b1, snap}));
            check("hold_r1_ready", 72'(req1_ready), 72'd0);
            @(negedge clk);
            #2;
        end
        rsp_ready = 1'b1;
        #1;
        check("hold_hs_r1", 72'({rsp_valid, req1_ready}), 72'd2);
        @(negedge clk);
        rsp_ready = 1'b0;
        #2;
        check("hold_after_hs", 72'({rsp_valid, req1_ready}), 72'd1);
        @(negedge clk);
        req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (4) @(negedge clk);

        // Reset during EXEC abandons the operation and restores req0 priority.
        req0_valid = 1'b1; req0_opcode = 6'd0; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_opcode = 6'd0; req1_a = 32'd2; req1_b = 32'd2;
        #2;
        check("rst_first_grant", 72'({req1_ready, req0_ready}), 72'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("rst_no_rsp", 72'(rsp_valid), 72'd0);
        check("rst_regrant", 72'({req1_ready, req0_ready}), 72'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        #2;
        check("rst_new_rsp", 72'({rsp_valid, rsp_id, rsp_result, rsp_err}), 72'({1'b1, 1'b0, 32'd2, 1'b0}));
        @(negedge clk);
        req1_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Randomized traffic; requesters hold valid until accepted.
        acc0 = 1'b0; acc1 = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (!req0_valid || acc0) begin
                req0_valid  = ($urandom_range(0, 2) != 0);
                req0_opcode = rnd_op();
                req0_a      = $urandom;
                req0_b      = ($urandom_range(0, 7) == 0) ? req0_a : $urandom;
            end
            if (!req1_valid || acc1) begin
                req1_valid  = ($urandom_range(0, 2) != 0);
                req1_opcode = rnd_op();
                req1_a      = $urandom;
                req1_b      = ($urandom_range(0, 7) == 0) ? req1_a : $urandom;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 99) == 0);
            #2;
            acc0 = req0_valid & req0_ready;
            acc1 = req1_valid & req1_ready;
        end

        @(negedge clk);
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (5) @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
